// File: rtl/t01_ai_pkg.sv
// Shared types and constants for the AI move-scoring slice.
package t01_ai_pkg;

  localparam int BOARD_ROWS = 20;
  localparam int BOARD_COLS = 10;
  localparam int BOARD_W    = BOARD_ROWS * BOARD_COLS;
  localparam int SCORE_W    = 20;
  localparam int IDX_W      = 6;

  localparam int unsigned NUM_CAND_DEF = 40;
  localparam int unsigned W_LINES_DEF  = 8;
  localparam int unsigned W_HOLES_DEF  = 4;
  localparam int unsigned W_BUMP_DEF   = 1;
  localparam int unsigned W_HEIGHT_DEF = 1;
  localparam int unsigned TIMEOUT_DEF  = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LAUNCH,
    S_WAIT_RDY,
    S_SCORE,
    S_GAP,
    S_DONE
  } scorer_state_e;

endpackage

// File: rtl/t01_ai_score_calc.sv
// Combinational weighted board score: lines add, holes/bumpiness/height subtract.
module t01_ai_score_calc
  import t01_ai_pkg::*;
#(
  parameter int unsigned W_LINES  = W_LINES_DEF,
  parameter int unsigned W_HOLES  = W_HOLES_DEF,
  parameter int unsigned W_BUMP   = W_BUMP_DEF,
  parameter int unsigned W_HEIGHT = W_HEIGHT_DEF
) (
  input  logic [2:0]                lines_cleared,
  input  logic [7:0]                holes,
  input  logic [7:0]                bumpiness,
  input  logic [7:0]                height_sum,
  output logic signed [SCORE_W-1:0] score
);

  logic [SCORE_W-1:0] gain;
  logic [SCORE_W-1:0] cost;

  always_comb begin
    gain  = SCORE_W'(W_LINES) * SCORE_W'(lines_cleared);
    cost  = SCORE_W'(W_HOLES) * SCORE_W'(holes)
          + SCORE_W'(W_BUMP) * SCORE_W'(bumpiness)
          + SCORE_W'(W_HEIGHT) * SCORE_W'(height_sum);
    score = signed'(gain - cost);
  end

endmodule

// File: rtl/t01_ai_move_scorer.sv
// Walks all candidate placements, extracts features of legal boards and keeps the best score.
module t01_ai_move_scorer
  import t01_ai_pkg::*;
#(
  parameter int unsigned NUM_CAND = NUM_CAND_DEF,
  parameter int unsigned W_LINES  = W_LINES_DEF,
  parameter int unsigned W_HOLES  = W_HOLES_DEF,
  parameter int unsigned W_BUMP   = W_BUMP_DEF,
  parameter int unsigned W_HEIGHT = W_HEIGHT_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      search_start,
  output logic                      cand_req,
  output logic [IDX_W-1:0]          cand_idx,
  input  logic                      cand_valid,
  input  logic                      cand_legal,
  input  logic [BOARD_W-1:0]        cand_board,
  output logic                      start_extract,
  output logic [BOARD_W-1:0]        next_board,
  input  logic                      extract_ready,
  input  logic [2:0]                lines_cleared,
  input  logic [7:0]                holes,
  input  logic [7:0]                bumpiness,
  input  logic [7:0]                height_sum,
  output logic                      search_done,
  output logic                      best_valid,
  output logic [IDX_W-1:0]          best_idx,
  output logic signed [SCORE_W-1:0] best_score,
  output logic                      timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  scorer_state_e state, state_d;

  logic                      req_gap;
  logic [TMO_W-1:0]          tmo_cnt;
  logic                      tmo_hit;
  logic                      cand_take;
  logic                      last_cand;
  logic                      ready_ok;
  logic [2:0]                lines_q;
  logic [7:0]                holes_q;
  logic [7:0]                bump_q;
  logic [7:0]                height_q;
  logic signed [SCORE_W-1:0] score;

  t01_ai_score_calc #(
    .W_LINES  (W_LINES),
    .W_HOLES  (W_HOLES),
    .W_BUMP   (W_BUMP),
    .W_HEIGHT (W_HEIGHT)
  ) u_score_calc (
    .lines_cleared (lines_q),
    .holes         (holes_q),
    .bumpiness     (bump_q),
    .height_sum    (height_q),
    .score         (score)
  );

  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign cand_take = (state == S_REQ) && !req_gap && cand_valid;
  assign last_cand = (cand_idx == LAST_IDX);
  // Ready only counts once it has been seen low after launch (stale ready filter).
  assign ready_ok  = (state == S_WAIT_RDY) && extract_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d     = state;
    cand_req    = 1'b0;
    search_done = 1'b0;
    case (state)
      S_IDLE:     if (search_start) state_d = S_REQ;
      S_REQ: begin
        cand_req = !req_gap && !cand_valid;
        if (cand_take) begin
          if (cand_legal)     state_d = S_LAUNCH;
          else if (last_cand) state_d = S_DONE;
        end
      end
      S_LAUNCH: begin
        if (tmo_hit)             state_d = S_DONE;
        else if (!extract_ready) state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (extract_ready)  state_d = S_SCORE;
        else if (tmo_hit)   state_d = S_DONE;
      end
      S_SCORE:    state_d = S_GAP;
      S_GAP:      state_d = last_cand ? S_DONE : S_REQ;
      S_DONE: begin
        search_done = 1'b1;
        state_d     = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_idx      <= '0;
      req_gap       <= 1'b0;
      next_board    <= '0;
      start_extract <= 1'b0;
      tmo_cnt       <= '0;
      lines_q       <= '0;
      holes_q       <= '0;
      bump_q        <= '0;
      height_q      <= '0;
      best_valid    <= 1'b0;
      best_idx      <= '0;
      best_score    <= '0;
      timeout_err   <= 1'b0;
    end else begin
      req_gap <= 1'b0;
      case (state)
        S_IDLE: begin
          if (search_start) begin
            cand_idx    <= '0;
            best_valid  <= 1'b0;
            best_idx    <= '0;
            best_score  <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_REQ: begin
          if (cand_take) begin
            if (cand_legal) begin
              next_board    <= cand_board;
              start_extract <= 1'b1;
              tmo_cnt       <= '0;
            end else if (!last_cand) begin
              cand_idx <= cand_idx + 1'b1;
              req_gap  <= 1'b1;
            end
          end
        end
        S_LAUNCH, S_WAIT_RDY: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (ready_ok) begin
            lines_q  <= lines_cleared;
            holes_q  <= holes;
            bump_q   <= bumpiness;
            height_q <= height_sum;
          end else if (tmo_hit) begin
            timeout_err   <= 1'b1;
            start_extract <= 1'b0;
          end
        end
        S_SCORE: begin
          start_extract <= 1'b0;
          if (!best_valid || (score > best_score)) begin
            best_valid <= 1'b1;
            best_idx   <= cand_idx;
            best_score <= score;
          end
        end
        S_GAP: begin
          if (!last_cand) begin
            cand_idx <= cand_idx + 1'b1;
            req_gap  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_t01_ai_move_scorer.sv
// Self-checking bench: random placement source and extractor models, reference best-move search.
module tb_t01_ai_move_scorer;
  import t01_ai_pkg::*;

  localparam int NC = 40;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               search_start = 1'b0;
  logic               cand_req;
  logic [5:0]         cand_idx;
  logic               cand_valid = 1'b0;
  logic               cand_legal = 1'b0;
  logic [199:0]       cand_board = '0;
  logic               start_extract;
  logic [199:0]       next_board;
  logic               extract_ready = 1'b0;
  logic [2:0]         lines_cleared = '0;
  logic [7:0]         holes = '0;
  logic [7:0]         bumpiness = '0;
  logic [7:0]         height_sum = '0;
  logic               search_done;
  logic               best_valid;
  logic [5:0]         best_idx;
  logic signed [19:0] best_score;
  logic               timeout_err;

  t01_ai_move_scorer #(
    .NUM_CAND (NC),
    .TIMEOUT  (64)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .search_start  (search_start),
    .cand_req      (cand_req),
    .cand_idx      (cand_idx),
    .cand_valid    (cand_valid),
    .cand_legal    (cand_legal),
    .cand_board    (cand_board),
    .start_extract (start_extract),
    .next_board    (next_board),
    .extract_ready (extract_ready),
    .lines_cleared (lines_cleared),
    .holes         (holes),
    .bumpiness     (bumpiness),
    .height_sum    (height_sum),
    .search_done   (search_done),
    .best_valid    (best_valid),
    .best_idx      (best_idx),
    .best_score    (best_score),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Candidate tables shared by the source and extractor models
  bit           legal_tbl [NC];
  logic [199:0] board_tbl [NC];
  int           f_l [NC];
  int           f_h [NC];
  int           f_b [NC];
  int           f_t [NC];

  int lat_max     = 2;
  int ext_extra   = 0;
  int stale_hold  = 0;
  bit never_ready = 1'b0;
  int board_miss  = 0;

  int   se_rises = 0;
  int   se_high  = 0;
  int   done_cnt = 0;
  logic se_prev  = 1'b0;

  always @(negedge clk) begin
    if (start_extract && !se_prev) se_rises <= se_rises + 1;
    if (start_extract)             se_high  <= se_high + 1;
    if (search_done)               done_cnt <= done_cnt + 1;
    se_prev <= start_extract;
  end

  initial begin : src
    int idx;
    forever begin
      @(negedge clk);
      if (cand_req && !reset) begin
        idx = int'(cand_idx);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        cand_valid = 1'b1;
        cand_legal = legal_tbl[idx];
        cand_board = board_tbl[idx];
        @(negedge clk);
        cand_valid = 1'b0;
      end
    end
  end

  // Extractor: drops ready when re-armed (optionally after a stale window), answers by board lookup
  initial begin : ext
    int   hit;
    logic se_last;
    se_last = 1'b0;
    forever begin
      @(negedge clk);
      if (start_extract && !se_last && !reset) begin
        if (stale_hold > 0) begin
          extract_ready = 1'b1;
          lines_cleared = 3'd7;
          holes = '0; bumpiness = '0; height_sum = '0;
          repeat (stale_hold) @(negedge clk);
        end
        extract_ready = 1'b0;
        if (!never_ready) begin
          repeat (ext_extra + $urandom_range(0, lat_max) + 1) @(negedge clk);
          if (start_extract) begin
            hit = -1;
            for (int i = 0; i < NC; i++) if (board_tbl[i] === next_board) hit = i;
            if (hit < 0) begin
              board_miss++;
            end else begin
              lines_cleared = 3'(f_l[hit]);
              holes         = 8'(f_h[hit]);
              bumpiness     = 8'(f_b[hit]);
              height_sum    = 8'(f_t[hit]);
            end
            extract_ready = 1'b1;
          end
        end
      end
      se_last = start_extract;
    end
  end

  task automatic gen(input int pct_legal, input bit ties);
    logic [223:0] wide;
    for (int i = 0; i < NC; i++) begin
      for (int k = 0; k < 7; k++) wide[k*32 +: 32] = $urandom;
      wide[5:0]    = 6'(i);
      board_tbl[i] = wide[199:0];
      legal_tbl[i] = ($urandom_range(0, 99) < pct_legal);
      f_l[i] = $urandom_range(0, 4);
      f_h[i] = $urandom_range(0, 30);
      f_b[i] = $urandom_range(0, 40);
      f_t[i] = $urandom_range(0, 150);
      if (ties && i > 0 && $urandom_range(0, 3) == 0) begin
        f_l[i] = f_l[i-1]; f_h[i] = f_h[i-1]; f_b[i] = f_b[i-1]; f_t[i] = f_t[i-1];
      end
    end
  endtask

  task automatic set_feat(input int i, input int l, input int h, input int b, input int t);
    legal_tbl[i] = 1'b1;
    f_l[i] = l; f_h[i] = h; f_b[i] = b; f_t[i] = t;
  endtask

  task automatic run_search(input string tag, input bit spurious);
    bit ev;
    int ei, es, s, nleg, exp_rises, r0, d0, h0, m0, n;
    ev = 1'b0; ei = 0; es = 0; nleg = 0;
    for (int i = 0; i < NC; i++) if (legal_tbl[i]) nleg++;
    for (int i = 0; i < NC; i++) begin
      if (legal_tbl[i]) begin
        if (never_ready) break;
        s = 8 * f_l[i] - 4 * f_h[i] - f_b[i] - f_t[i];
        if (!ev || s > es) begin ev = 1'b1; ei = i; es = s; end
      end
    end
    exp_rises = never_ready ? (nleg > 0 ? 1 : 0) : nleg;

    @(negedge clk);
    r0 = se_rises; d0 = done_cnt; h0 = se_high; m0 = board_miss;
    search_start = 1'b1;
    @(negedge clk);
    search_start = 1'b0;
    check({tag, "_tmo_clear"}, timeout_err, 0);
    n = 0;
    while (!search_done && n < 4000) begin
      @(negedge clk);
      n++;
      search_start = (spurious && n == 25);
    end
    search_start = 1'b0;
    if (!search_done) begin
      check({tag, "_done_seen"}, 0, 1);
      return;
    end
    check({tag, "_best_valid"}, best_valid, ev);
    check({tag, "_best_idx"},   best_idx, ei);
    check({tag, "_best_score"}, best_score, es);
    check({tag, "_timeout_err"}, timeout_err, never_ready && nleg > 0);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_done_low"}, search_done, 0);
    check({tag, "_extract_starts"}, se_rises - r0, exp_rises);
    check({tag, "_extract_idle"}, start_extract, 0);
    check({tag, "_board_match"}, board_miss - m0, 0);
    check({tag, "_best_hold"}, best_score, es);
    if (never_ready && nleg > 0) check({tag, "_tmo_cycles"}, se_high - h0, 64);
  endtask

  initial begin
    int n;
    for (int i = 0; i < NC; i++) begin
      legal_tbl[i] = 1'b0; board_tbl[i] = '0;
      f_l[i] = 0; f_h[i] = 0; f_b[i] = 0; f_t[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_cand_req", cand_req, 0);
    check("rst_cand_idx", cand_idx, 0);
    check("rst_start_extract", start_extract, 0);
    check("rst_next_board", |next_board, 0);
    check("rst_search_done", search_done, 0);
    check("rst_best_valid", best_valid, 0);
    check("rst_best_idx", best_idx, 0);
    check("rst_best_score", best_score, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    gen(0, 1'b0);
    set_feat(0, 1, 2, 3, 10);
    run_search("single", 1'b0);

    gen(0, 1'b0);
    set_feat(0, 1, 2, 3, 10);
    set_feat(1, 1, 1, 0, 0);
    set_feat(2, 1, 1, 0, 0);
    run_search("tie", 1'b0);

    stale_hold = 2;
    run_search("stale", 1'b0);
    stale_hold = 0;

    gen(0, 1'b0);
    set_feat(1, 2, 5, 7, 30);
    run_search("mid_legal", 1'b0);

    gen(0, 1'b0);
    run_search("none_legal", 1'b0);

    gen(0, 1'b0);
    set_feat(0, 1, 2, 3, 10);
    never_ready = 1'b1;
    run_search("timeout", 1'b0);
    never_ready = 1'b0;

    gen(0, 1'b0);
    set_feat(0, 1, 2, 3, 10);
    run_search("post_timeout", 1'b0);

    // Reset while waiting on a slow extractor
    gen(0, 1'b0);
    set_feat(0, 3, 1, 2, 4);
    ext_extra = 30;
    @(negedge clk);
    search_start = 1'b1;
    @(negedge clk);
    search_start = 1'b0;
    n = 0;
    while (!(start_extract && !extract_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("rst_mid_reach_wait", 0, 1);
    end else begin
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_start_extract", start_extract, 0);
      check("rst_mid_cand_req", cand_req, 0);
      check("rst_mid_cand_idx", cand_idx, 0);
      check("rst_mid_next_board", |next_board, 0);
      check("rst_mid_best_valid", best_valid, 0);
      check("rst_mid_best_score", best_score, 0);
      check("rst_mid_search_done", search_done, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (45) @(negedge clk);
    ext_extra = 0;
    run_search("after_reset", 1'b0);

    for (int r = 0; r < 4; r++) begin
      gen($urandom_range(20, 80), 1'b1);
      stale_hold = $urandom_range(0, 2);
      run_search($sformatf("rand%0d", r), r[0]);
    end
    stale_hold = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
